ddr3_app_sequencer: RTL

Drains the DDR3 write FIFO and read-request FIFO and issues the corresponding commands on the MIG 7-series user (app) interface. It sits between the cache-side FIFOs and the MIG core. Each 128-bit cache line is split into two 64-bit app transactions; read beats are reassembled into a line and pushed, with their address, into the read-out FIFO.

---
 rtl/ddr3_pkg.sv | 29 ++
 rtl/ddr3_rd_assembler.sv | 63 ++++++
 rtl/ddr3_app_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_pkg
// Purpose  : State encoding, MIG command codes and line geometry shared by
//            the DDR3 app-interface sequencer and its read assembler.
// Revision : 1.0
// ============================================================================
package ddr3_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR0     = 3'd1,
      WR1     = 3'd2,
      RD0     = 3'd3,
      RD1     = 3'd4,
      RD_WAIT = 3'd5,
      RD_PUSH = 3'd6
   } ddr3_seq_state_t;

   localparam logic [2:0] APP_CMD_WRITE = 3'b000;
   localparam logic [2:0] APP_CMD_READ  = 3'b001;

   localparam int LINE_BYTES       = 16;
   localparam int BEAT_BYTES       = 8;
   localparam int BEATS_PER_LINE   = LINE_BYTES / BEAT_BYTES;
   localparam int LINE_OFFSET_BITS = 4;

endpackage
`default_nettype wire

// File: rtl/ddr3_rd_assembler.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_rd_assembler
// Purpose  : Collects two app read beats (low half first) into one line.
// Revision : 1.0
// ============================================================================
module ddr3_rd_assembler
   import ddr3_pkg::*;
#(
   parameter int BEAT_WIDTH = 64
) (
   input  logic                                 clk_i,
   input  logic                                 rst_n_i,
   input  logic                                 clear_i,
   input  logic                                 capture_en_i,
   input  logic                                 valid_i,
   input  logic [BEAT_WIDTH-1:0]                data_i,
   output logic [BEATS_PER_LINE*BEAT_WIDTH-1:0] line_o,
   output logic                                 done_o
);

   localparam int LINE_WIDTH = BEATS_PER_LINE * BEAT_WIDTH;

   logic                  beat_q, beat_d;
   logic                  done_q, done_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;

   always_comb begin
      beat_d = beat_q;
      done_d = done_q;
      line_d = line_q;
      if (clear_i) begin
         beat_d = 1'b0;
         done_d = 1'b0;
      end else if (capture_en_i && valid_i) begin
         if (!beat_q) begin
            line_d[BEAT_WIDTH-1:0] = data_i;
            beat_d                 = 1'b1;
         end else begin
            line_d[LINE_WIDTH-1:BEAT_WIDTH] = data_i;
            beat_d                          = 1'b0;
            done_d                          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         beat_q <= 1'b0;
         done_q <= 1'b0;
         line_q <= '0;
      end else begin
         beat_q <= beat_d;
         done_q <= done_d;
         line_q <= line_d;
      end
   end

   assign line_o = line_q;
   assign done_o = done_q;

endmodule
`default_nettype wire

// File: rtl/ddr3_app_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_app_sequencer
// Purpose  : Drains cache write/read-request FIFOs into MIG app commands,
//            two 64-bit beats per 128-bit line. DDR3_SEQ_PERF_CNT_EN adds
//            line and stall counters.
// Revision : 1.0
// ============================================================================
module ddr3_app_sequencer
   import ddr3_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 128,
   parameter int APP_ADDR_WIDTH = 29,
   parameter int APP_DATA_WIDTH = 64
) (
   input  logic                        CLK,
   input  logic                        RSTn,
   input  logic                        init_calib_complete,
   input  logic                        write_fifo_empty,
   input  logic [ADDRESS_WIDTH-1:0]    write_fifo_address,
   input  logic [DATA_WIDTH-1:0]       write_fifo_data,
   output logic                        write_fifo_read,
   input  logic                        read_in_fifo_empty,
   input  logic [ADDRESS_WIDTH-1:0]    read_in_fifo_address,
   output logic                        read_in_fifo_read,
   input  logic                        read_out_fifo_full,
   output logic                        read_out_fifo_address_write,
   output logic                        read_out_fifo_data_write,
   output logic [ADDRESS_WIDTH-1:0]    read_out_fifo_address,
   output logic [DATA_WIDTH-1:0]       read_out_fifo_data,
   output logic [APP_ADDR_WIDTH-1:0]   app_addr,
   output logic [2:0]                  app_cmd,
   output logic                        app_en,
   input  logic                        app_rdy,
   output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
   output logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
   output logic                        app_wdf_wren,
   output logic                        app_wdf_end,
   input  logic                        app_wdf_rdy,
   input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
   input  logic                        app_rd_data_valid
`ifdef DDR3_SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                 wr_line_count,
   output logic [31:0]                 rd_line_count,
   output logic [31:0]                 stall_count
`endif
);

   localparam logic [ADDRESS_WIDTH-1:0] LINE_ADDR_MASK =
      {{(ADDRESS_WIDTH-LINE_OFFSET_BITS){1'b1}}, {LINE_OFFSET_BITS{1'b0}}};

   ddr3_seq_state_t            state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
   logic                       cmd_done_q, cmd_done_d;
   logic                       wdf_done_q, wdf_done_d;
   logic                       wr_pop_q, wr_pop_d;

   logic                       w_is_wr, w_is_rd_cmd, w_beat_sel;
   logic                       w_cmd_fire, w_wdf_fire, w_cmd_ok, w_wdf_ok;
   logic                       w_rd_done;
   logic [DATA_WIDTH-1:0]      w_line;

   assign w_is_wr     = (state_q == WR0) || (state_q == WR1);
   assign w_is_rd_cmd = (state_q == RD0) || (state_q == RD1);
   assign w_beat_sel  = (state_q == WR1) || (state_q == RD1);

   // Moore outputs: decoded from state and done flags only.
   assign app_en       = (w_is_wr || w_is_rd_cmd) && !cmd_done_q;
   assign app_cmd      = w_is_rd_cmd ? APP_CMD_READ : APP_CMD_WRITE;
   assign app_addr     = (w_is_wr || w_is_rd_cmd) ?
                         {addr_q[APP_ADDR_WIDTH-1:LINE_OFFSET_BITS], w_beat_sel, 3'b000} : '0;
   assign app_wdf_wren = w_is_wr && !wdf_done_q;
   assign app_wdf_end  = w_is_wr && !wdf_done_q;
   assign app_wdf_mask = '0;
   assign app_wdf_data = (state_q == WR0) ? wdata_q[APP_DATA_WIDTH-1:0] :
                         (state_q == WR1) ? wdata_q[DATA_WIDTH-1 -: APP_DATA_WIDTH] : '0;

   assign write_fifo_read             = wr_pop_q;
   assign read_in_fifo_read           = (state_q == RD_PUSH);
   assign read_out_fifo_address_write = (state_q == RD_PUSH);
   assign read_out_fifo_data_write    = (state_q == RD_PUSH);
   assign read_out_fifo_address       = addr_q;
   assign read_out_fifo_data          = w_line;

   assign w_cmd_fire = app_en && app_rdy;
   assign w_wdf_fire = app_wdf_wren && app_wdf_rdy;
   assign w_cmd_ok   = cmd_done_q || w_cmd_fire;
   assign w_wdf_ok   = wdf_done_q || w_wdf_fire;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cmd_done_d = cmd_done_q;
      wdf_done_d = wdf_done_q;
      wr_pop_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // The pop is registered, so the show-ahead head is stale for one cycle.
            if (init_calib_complete && !wr_pop_q) begin
               if (!write_fifo_empty) begin
                  addr_d  = write_fifo_address & LINE_ADDR_MASK;
                  wdata_d = write_fifo_data;
                  state_d = WR0;
               end else if (!read_in_fifo_empty && !read_out_fifo_full) begin
                  addr_d  = read_in_fifo_address & LINE_ADDR_MASK;
                  state_d = RD0;
               end
            end
         end
         WR0, WR1: begin
            if (w_cmd_ok && w_wdf_ok) begin
               cmd_done_d = 1'b0;
               wdf_done_d = 1'b0;
               if (state_q == WR0) begin
                  state_d = WR1;
               end else begin
                  state_d  = IDLE;
                  wr_pop_d = 1'b1;
               end
            end else begin
               cmd_done_d = w_cmd_ok;
               wdf_done_d = w_wdf_ok;
            end
         end
         RD0:     if (w_cmd_fire) state_d = RD1;
         RD1:     if (w_cmd_fire) state_d = RD_WAIT;
         RD_WAIT: if (w_rd_done) state_d = RD_PUSH;
         RD_PUSH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         cmd_done_q <= 1'b0;
         wdf_done_q <= 1'b0;
         wr_pop_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cmd_done_q <= cmd_done_d;
         wdf_done_q <= wdf_done_d;
         wr_pop_q   <= wr_pop_d;
      end
   end

   ddr3_rd_assembler #(
      .BEAT_WIDTH (APP_DATA_WIDTH)
   ) u_rd_assembler (
      .clk_i        (CLK),
      .rst_n_i      (RSTn),
      .clear_i      (state_q == IDLE),
      .capture_en_i ((state_q == RD1) || (state_q == RD_WAIT)),
      .valid_i      (app_rd_data_valid),
      .data_i       (app_rd_data),
      .line_o       (w_line),
      .done_o       (w_rd_done)
   );

`ifdef DDR3_SEQ_PERF_CNT_EN
   logic [31:0] wr_cnt_q, rd_cnt_q, stall_cnt_q;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (write_fifo_read)    wr_cnt_q    <= wr_cnt_q + 32'd1;
         if (read_in_fifo_read)  rd_cnt_q    <= rd_cnt_q + 32'd1;
         if (app_en && !app_rdy) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign wr_line_count = wr_cnt_q;
   assign rd_line_count = rd_cnt_q;
   assign stall_count   = stall_cnt_q;
`endif

endmodule
`default_nettype wire
